// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg -- shared types and constants for the instruction-fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   typedef enum logic [1:0] {
      RST  = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam int PC_SEL_BR = 0;
   localparam int PC_SEL_JR = 1;
   localparam int PC_SEL_J  = 2;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// next_pc_calc -- combinational next-PC selection (j/jal > jr > branch > +4)
// Rev 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
   import fetch_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] IM_instr,
   input  logic [31:0] rs_data,
   input  logic [2:0]  pc_sel,
   output logic [31:0] next_pc,
   output logic        misalign
);

   logic [31:0] br_offset;

   always_comb begin
      br_offset = {{14{IM_instr[15]}}, IM_instr[15:0], 2'b00};
      next_pc   = pc_plus4;
      misalign  = 1'b0;
      if (pc_sel[PC_SEL_J]) begin
         next_pc = {pc_plus4[31:28], IM_instr[25:0], 2'b00};
      end else if (pc_sel[PC_SEL_JR]) begin
         // Low bits are forced to zero; the fault is only flagged, not trapped.
         next_pc  = {rs_data[31:2], 2'b00};
         misalign = |rs_data[1:0];
      end else if (pc_sel[PC_SEL_BR]) begin
         next_pc = pc_plus4 + br_offset;
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch -- PC owner and imem req/ack fetch FSM feeding the decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IM_instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [2:0]  pc_sel,
   input  logic [31:0] rs_data,
   input  logic        commit,
   output logic        addr_err
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         addr_err_q, addr_err_d;

   logic [31:0]  next_pc;
   logic         misalign;
   logic [31:0]  seq_pc;

   assign seq_pc = pc_q + 32'd4;

   next_pc_calc u_next_pc_calc (
      .pc_plus4 (seq_pc),
      .IM_instr (instr_q),
      .rs_data  (rs_data),
      .pc_sel   (pc_sel),
      .next_pc  (next_pc),
      .misalign (misalign)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      addr_err_d = addr_err_q;
      case (state_q)
         RST: begin
            state_d = REQ;
         end
         REQ: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (commit) begin
               pc_d    = next_pc;
               state_d = REQ;
               if (misalign) begin
                  addr_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = RST;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RST;
         pc_q       <= RESET_PC;
         instr_q    <= 32'd0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Every output is decoded from registered state; nothing passes through from ack/commit.
   assign imem_req    = (state_q == REQ);
   assign imem_addr   = pc_q;
   assign IM_instr    = instr_q;
   assign instr_valid = (state_q == HOLD);
   assign pc          = pc_q;
   assign pc_plus4    = seq_pc;
   assign addr_err    = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch -- directed and randomized checks of instr_fetch against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [2:0]  pc_sel = 3'd0;
   logic [31:0] rs_data = 32'd0;
   logic        commit = 1'b0;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] IM_instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        addr_err;

   int errors = 0;
   int checks = 0;

   instr_fetch #(.RESET_PC(32'h0040_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .IM_instr    (IM_instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .pc_sel      (pc_sel),
      .rs_data     (rs_data),
      .commit      (commit),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the next address an instruction leads to, by plain arithmetic.
   function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] instr,
                                            input logic [31:0] rs, input logic [2:0] sel);
      logic [31:0] seq;
      int          off;
      seq = cur_pc + 32'd4;
      off = int'($signed(instr[15:0])) * 4;
      if (sel[2]) return (seq & 32'hF000_0000) | ({6'd0, instr[25:0]} * 32'd4);
      if (sel[1]) return rs & ~32'd3;
      if (sel[0]) return seq + 32'(off);
      return seq;
   endfunction

   function automatic logic ref_bad(input logic [31:0] rs, input logic [2:0] sel);
      return !sel[2] && sel[1] && ((rs % 4) != 0);
   endfunction

   logic [31:0] m_pc      = 32'h0040_0000;
   logic [31:0] m_instr   = 32'd0;
   logic        m_have    = 1'b0;
   logic        m_started = 1'b0;
   logic        m_err     = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc      <= 32'h0040_0000;
         m_instr   <= 32'd0;
         m_have    <= 1'b0;
         m_started <= 1'b0;
         m_err     <= 1'b0;
      end else if (!m_started) begin
         m_started <= 1'b1;
      end else if (!m_have) begin
         if (imem_ack) begin
            m_instr <= imem_rdata;
            m_have  <= 1'b1;
         end
      end else if (commit) begin
         m_pc   <= ref_next(m_pc, m_instr, rs_data, pc_sel);
         m_err  <= m_err | ref_bad(rs_data, pc_sel);
         m_have <= 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("model_imem_req",    {31'd0, imem_req},    {31'd0, m_started && !m_have});
      chk("model_imem_addr",   imem_addr,            m_pc);
      chk("model_instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
      chk("model_IM_instr",    IM_instr,             m_instr);
      chk("model_pc",          pc,                   m_pc);
      chk("model_pc_plus4",    pc_plus4,             m_pc + 32'd4);
      chk("model_addr_err",    {31'd0, addr_err},    {31'd0, m_err});
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"},      {31'd0, imem_req},    32'd0);
      chk({tag, "_addr"},     imem_addr,            32'h0040_0000);
      chk({tag, "_pc"},       pc,                   32'h0040_0000);
      chk({tag, "_pc_plus4"}, pc_plus4,             32'h0040_0004);
      chk({tag, "_instr"},    IM_instr,             32'd0);
      chk({tag, "_valid"},    {31'd0, instr_valid}, 32'd0);
      chk({tag, "_err"},      {31'd0, addr_err},    32'd0);
   endtask

   // Assumes the DUT is in its request phase; leaves it requesting the next address.
   task automatic fetch_commit(input logic [31:0] instr, input logic [2:0] sel, input logic [31:0] rs);
      imem_ack   = 1'b1;
      imem_rdata = instr;
      tick();
      imem_ack = 1'b0;
      commit   = 1'b1;
      pc_sel   = sel;
      rs_data  = rs;
      tick();
      commit = 1'b0;
      pc_sel = 3'd0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 check_reset_vals("reset");
      tick();
      tick();

      // Back-to-back fetches with ack tied high
      imem_ack   = 1'b1;
      imem_rdata = 32'h2008_0005;
      commit     = 1'b1;
      rst_n      = 1'b1;
      tick();
      chk("first_req",   {31'd0, imem_req}, 32'd1);
      chk("first_addr",  imem_addr, 32'h0040_0000);
      tick();
      chk("first_valid", {31'd0, instr_valid}, 32'd1);
      chk("first_instr", IM_instr, 32'h2008_0005);
      tick();
      chk("seq_addr1",   imem_addr, 32'h0040_0004);
      tick();
      tick();
      chk("seq_addr2",   imem_addr, 32'h0040_0008);

      // Delayed ack
      imem_ack = 1'b0;
      commit   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_req",   {31'd0, imem_req}, 32'd1);
         chk("wait_addr",  imem_addr, 32'h0040_0008);
         chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'h0810_0004;
      tick();
      chk("late_valid", {31'd0, instr_valid}, 32'd1);
      imem_ack = 1'b0;
      commit   = 1'b1;
      pc_sel   = 3'b100;
      tick();
      commit = 1'b0;
      pc_sel = 3'd0;
      chk("j_to_0x10", imem_addr, 32'h0040_0010);

      // Branches from 0x0040_0010
      fetch_commit(32'h1000_FFFC, 3'b001, 32'd0);
      chk("br_back",     imem_addr, 32'h0040_0004);
      fetch_commit(32'h0810_0004, 3'b100, 32'd0);
      fetch_commit(32'h1000_0003, 3'b001, 32'd0);
      chk("br_fwd",      imem_addr, 32'h0040_0020);

      // Jumps from 0x0040_0000, including all select bits set
      fetch_commit(32'h0810_0000, 3'b100, 32'd0);
      chk("j_to_base",   imem_addr, 32'h0040_0000);
      fetch_commit(32'h0810_0008, 3'b100, 32'd0);
      chk("j_plain",     imem_addr, 32'h0040_0020);
      fetch_commit(32'h0810_0000, 3'b100, 32'd0);
      fetch_commit(32'h0810_0008, 3'b111, 32'h0000_0003);
      chk("j_priority",  imem_addr, 32'h0040_0020);
      chk("j_no_err",    {31'd0, addr_err}, 32'd0);

      // Misaligned jr
      fetch_commit(32'h0000_0008, 3'b010, 32'h0040_0102);
      chk("jr_addr",     imem_addr, 32'h0040_0100);
      chk("jr_err",      {31'd0, addr_err}, 32'd1);
      fetch_commit(32'h0000_0000, 3'b000, 32'd0);
      chk("seq_after_jr", imem_addr, 32'h0040_0104);
      chk("err_sticky",  {31'd0, addr_err}, 32'd1);

      // Reset during a request, with ack/commit activity while held
      rst_n = 1'b0;
      #1 check_reset_vals("rst_req");
      imem_ack = 1'b1;
      commit   = 1'b1;
      tick();
      tick();
      check_reset_vals("rst_held");
      imem_ack = 1'b0;
      commit   = 1'b0;
      rst_n    = 1'b1;
      tick();
      chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0040_0000);

      // Reset during hold
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      imem_ack = 1'b0;
      rst_n    = 1'b0;
      #1 check_reset_vals("rst_hold");
      tick();
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         imem_ack   = ($urandom_range(0, 9) < 6);
         imem_rdata = $urandom;
         commit     = ($urandom_range(0, 9) < 6);
         pc_sel     = 3'($urandom_range(0, 7));
         rs_data    = $urandom;
         if ($urandom_range(0, 1) == 0) rs_data[1:0] = 2'b00;
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      end
      rst_n = 1'b1;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
